// File: rtl/pipe_adder.sv
// pipe_adder: streaming two's-complement add/subtract, split into STAGES carry-registered chunks.
// Optional OVF/ZERO flag logic is compiled in with PIPE_ADDER_FLAGS_EN.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO
);

    localparam int CW = WIDTH / STAGES;

    function automatic logic [CW:0] chunk_add(input logic [CW-1:0] a,
                                              input logic [CW-1:0] b,
                                              input logic          c);
        return {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, c};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // The whole pipeline advances together; it only freezes when the head beat is blocked.
    assign adv      = !(OUT_VALID && !OUT_READY);
    assign IN_READY = RST_N && adv;
    assign b_eff    = SUB ? ~B : B;
    assign c0       = SUB ? ~CIN : CIN;

`ifdef PIPE_ADDER_FLAGS_EN
    logic ovf_p;
    logic zero_p;
    assign OVF  = ovf_p;
    assign ZERO = zero_p;
`else
    assign OVF  = 1'b0;
    assign ZERO = 1'b0;
`endif

    for (genvar s = 0; s < STAGES; s++) begin : stg
        localparam int IW = WIDTH - s * CW;
        localparam int LO = (s + 1) * CW;

        logic [IW-1:0] a_in;
        logic [IW-1:0] b_in;
        logic          c_in;
        logic          v_in;
        logic [CW:0]   add;
        logic [LO-1:0] sum_nx;
        logic [LO-1:0] sum_p;
        logic          cy_p;
        logic          vld_p;

        if (s == 0) begin : g_src
            assign a_in   = A;
            assign b_in   = b_eff;
            assign c_in   = c0;
            assign v_in   = IN_VALID && IN_READY;
            assign sum_nx = add[CW-1:0];
        end else begin : g_src
            // Operand chunks not yet consumed and finished low sum chunks ride along as skew/deskew.
            assign a_in   = stg[s-1].g_up.a_p;
            assign b_in   = stg[s-1].g_up.b_p;
            assign c_in   = stg[s-1].cy_p;
            assign v_in   = stg[s-1].vld_p;
            assign sum_nx = {add[CW-1:0], stg[s-1].sum_p};
        end

        assign add = chunk_add(a_in[CW-1:0], b_in[CW-1:0], c_in);

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                vld_p <= 1'b0;
            end else if (adv) begin
                vld_p <= v_in;
            end
        end

        if (s < STAGES - 1) begin : g_up
            logic [IW-CW-1:0] a_p;
            logic [IW-CW-1:0] b_p;

            always_ff @(posedge CLK) begin
                if (adv) begin
                    a_p   <= a_in[IW-1:CW];
                    b_p   <= b_in[IW-1:CW];
                    sum_p <= sum_nx;
                    cy_p  <= add[CW];
                end
            end
        end else begin : g_out
            // Output registers load only on real beats so an empty pipe keeps the last result.
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    sum_p <= '0;
                    cy_p  <= 1'b0;
                end else if (adv && v_in) begin
                    sum_p <= sum_nx;
                    cy_p  <= add[CW];
                end
            end

`ifdef PIPE_ADDER_FLAGS_EN
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    ovf_p  <= 1'b0;
                    zero_p <= 1'b0;
                end else if (adv && v_in) begin
                    ovf_p  <= (a_in[CW-1] == b_in[CW-1]) && (sum_nx[WIDTH-1] != a_in[CW-1]);
                    zero_p <= ~|sum_nx;
                end
            end
`endif

            assign OUT_VALID = vld_p;
            assign SUM       = sum_p;
            assign COUT      = cy_p;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=32, STAGES=4): reset, carry chain, subtract,
// streaming, backpressure, empty-pipe hold and mid-flight reset.
module tb_pipe_adder;

`ifdef PIPE_ADDER_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic        CLK;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] A;
    logic [31:0] B;
    logic        CIN;
    logic        SUB;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] SUM;
    logic        COUT;
    logic        OVF;
    logic        ZERO;

    int n_vec = 0;
    int n_bad = 0;

    pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .CIN(CIN), .SUB(SUB),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .SUM(SUM), .COUT(COUT), .OVF(OVF), .ZERO(ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One isolated beat: output must be absent for 3 edges after the accept edge, present on the 4th.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic [31:0] es,
                           input logic ec, input logic eo, input logic ez);
        A = a; B = b; CIN = cin; SUB = sub; IN_VALID = 1'b1;
        #1;
        chk1({tag, ".in_ready"}, IN_READY, 1'b1);
        tick();
        IN_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1({tag, ".early"}, OUT_VALID, 1'b0);
            tick();
        end
        chk1 ({tag, ".valid"}, OUT_VALID, 1'b1);
        chk32({tag, ".sum"},   SUM, es);
        chk1 ({tag, ".cout"},  COUT, ec);
        chk1 ({tag, ".ovf"},   OVF, eo);
        chk1 ({tag, ".zero"},  ZERO, ez);
    endtask

    initial begin
        RST_N = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
        A = 32'd1; B = 32'd1; CIN = 1'b0; SUB = 1'b0;

        // Reset held for two edges with a beat offered
        tick();
        tick();
        chk1 ("rst.in_ready", IN_READY, 1'b0);
        chk1 ("rst.out_valid", OUT_VALID, 1'b0);
        chk32("rst.sum", SUM, 32'h0);
        chk1 ("rst.cout", COUT, 1'b0);
        chk1 ("rst.ovf", OVF, 1'b0);
        chk1 ("rst.zero", ZERO, 1'b0);
        RST_N = 1'b1; IN_VALID = 1'b0;
        #1;
        chk1("rst.release_ready", IN_READY, 1'b1);
        tick();
        chk1("rst.no_beat", OUT_VALID, 1'b0);

        // Carry chain and overflow
        run_one("cc.ones",  32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, FL);
        run_one("cc.ovf",   32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, FL,   1'b0);
        run_one("cc.chunk", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0);

        // Subtract
        run_one("sub.neg",  32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub.ovf",  32'h8000_0000, 32'h1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, FL,   1'b0);
        run_one("sub.bin",  32'd9,         32'd4,         1'b1, 1'b1, 32'd4,         1'b1, 1'b0, 1'b0);
        run_one("sub.zero", 32'd6,         32'd6,         1'b0, 1'b1, 32'h0,         1'b1, 1'b0, FL);

        // Empty pipeline: result drains, SUM holds, OUT_READY irrelevant
        tick();
        chk1 ("empty.valid", OUT_VALID, 1'b0);
        chk32("empty.sum", SUM, 32'h0);
        chk1 ("empty.cout", COUT, 1'b1);
        OUT_READY = 1'b0;
        #1;
        chk1("empty.in_ready", IN_READY, 1'b1);
        tick();
        chk1 ("empty.valid2", OUT_VALID, 1'b0);
        chk32("empty.sum2", SUM, 32'h0);
        OUT_READY = 1'b1;

        // Streaming: 8 back-to-back beats
        for (int c = 0; c <= 10; c++) begin
            if (c < 8) begin
                IN_VALID = 1'b1; A = 32'(c); B = 32'(c); CIN = 1'b0; SUB = 1'b0;
                #1;
                chk1("stream.in_ready", IN_READY, 1'b1);
            end else begin
                IN_VALID = 1'b0;
            end
            tick();
            chk1("stream.valid", OUT_VALID, (c >= 3));
            if (c >= 3) chk32("stream.sum", SUM, 32'(2 * (c - 3)));
        end
        IN_VALID = 1'b0;

        // Backpressure with 3 beats in flight
        for (int k = 0; k < 3; k++) begin
            IN_VALID = 1'b1; A = 32'(32'h1111_1111 * (k + 1)); B = 32'h0F0F_0F0F;
            tick();
        end
        IN_VALID = 1'b0;
        tick();
        chk1 ("bp.head_valid", OUT_VALID, 1'b1);
        chk32("bp.head_sum", SUM, 32'h2020_2020);
        OUT_READY = 1'b0;
        #1;
        chk1("bp.in_ready_low", IN_READY, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1 ("bp.hold_valid", OUT_VALID, 1'b1);
            chk32("bp.hold_sum", SUM, 32'h2020_2020);
            chk1 ("bp.hold_ready", IN_READY, 1'b0);
        end
        OUT_READY = 1'b1;
        #1;
        chk1("bp.in_ready_back", IN_READY, 1'b1);
        tick();
        chk1 ("bp.b1_valid", OUT_VALID, 1'b1);
        chk32("bp.b1_sum", SUM, 32'h3131_3131);
        tick();
        chk1 ("bp.b2_valid", OUT_VALID, 1'b1);
        chk32("bp.b2_sum", SUM, 32'h4242_4242);
        tick();
        chk1("bp.drained", OUT_VALID, 1'b0);

        // Mid-flight reset: two beats discarded, new beat accepted on first edge after release
        IN_VALID = 1'b1; A = 32'd1; B = 32'd1;
        tick();
        A = 32'd2; B = 32'd2;
        tick();
        IN_VALID = 1'b0; RST_N = 1'b0;
        tick();
        chk1 ("mid.valid", OUT_VALID, 1'b0);
        chk32("mid.sum", SUM, 32'h0);
        chk1 ("mid.in_ready", IN_READY, 1'b0);
        RST_N = 1'b1;
        run_one("mid.after", 32'd9, 32'd4, 1'b1, 1'b1, 32'd4, 1'b1, 1'b0, 1'b0);
        tick();
        chk1("mid.final_drain", OUT_VALID, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
